stopwatch_lap_controller: RTL and testbench

- Control FSM for the 4-digit BCD stopwatch counter chain.
- Converts debounced start/stop, lap and reset button levels into:
  - the chain's pause (set) and clear (reset) controls;
  - a timed split-display freeze;
  - a circular lap memory that can be browsed while stopped.
- Sits between the Module_Monostable button conditioners and the LED output multiplexer.
- Replaces the ad-hoc toggle logic in the stopwatch top level.

---
 rtl/stopwatch_lap_controller_pkg.sv | 23 ++
 rtl/stopwatch_lap_controller_buffer.sv | 71 +++++++
 rtl/stopwatch_lap_controller.sv | 154 +++++++++++++++
 tb/tb_stopwatch_lap_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_lap_controller_pkg.sv
// ============================================================================
// Module      : stopwatch_lap_controller_pkg
// Description : Shared state encodings and widths for the stopwatch lap controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_lap_controller_pkg;

    localparam int          C_BCD_W               = 16;
    localparam logic [31:0] C_HOLD_CYCLES_DEFAULT = 32'd100_000_000;

    typedef enum logic [2:0] {
        ST_CLEARED = 3'd0,
        ST_RUNNING = 3'd1,
        ST_SPLIT   = 3'd2,
        ST_STOPPED = 3'd3,
        ST_RECALL  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/stopwatch_lap_controller_buffer.sv
// ============================================================================
// Module      : stopwatch_lap_buffer
// Description : Circular DEPTH x 16 lap store, read by age (0 = newest).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_lap_buffer
    import stopwatch_lap_controller_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [C_BCD_W-1:0] wr_data,
    input  logic               clr,
    input  logic [IW-1:0]      rd_age,
    output logic [C_BCD_W-1:0] rd_data,
    output logic [CW-1:0]      count
);

    logic [C_BCD_W-1:0] mem_q [DEPTH];
    logic [IW-1:0]      wp_q, wp_d;
    logic [CW-1:0]      count_q, count_d;
    logic [C_BCD_W-1:0] rd_data_q, rd_data_d;
    logic [IW-1:0]      rd_addr;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    always_comb begin
        rd_addr   = wp_q - IW'(1) - rd_age;
        rd_data_d = mem_q[rd_addr];
        wp_d      = wp_q;
        count_d   = count_q;
        if (clr) begin
            wp_d    = '0;
            count_d = '0;
        end else if (wr_en) begin
            wp_d = wp_q + IW'(1);
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wp_q      <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wp_q      <= wp_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_lap_controller.sv
// ============================================================================
// Module      : stopwatch_lap_controller
// Description : Start/stop, split-hold and lap-recall control for the BCD stopwatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_lap_controller
    import stopwatch_lap_controller_pkg::*;
#(
    parameter  int          DEPTH       = 4,
    parameter  logic [31:0] HOLD_CYCLES = C_HOLD_CYCLES_DEFAULT,
    localparam int          IW          = $clog2(DEPTH),
    localparam int          CW          = $clog2(DEPTH + 1)
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               btn_start_stop,
    input  logic               btn_lap,
    input  logic               btn_clear,
    input  logic [C_BCD_W-1:0] time_bcd,
    output logic               pause,
    output logic               counter_reset,
    output logic [C_BCD_W-1:0] display_bcd,
    output logic               lap_view,
    output logic [CW-1:0]      lap_count,
    output logic [IW-1:0]      recall_idx,
    output logic [2:0]         state
);

    logic [2:0]         btn_prev_q;
    logic               armed_q;
    logic [2:0]         rise;
    logic               ev_start, ev_lap, ev_clear;

    state_t             state_q, state_d;
    logic [31:0]        hold_q, hold_d;
    logic [C_BCD_W-1:0] split_q, split_d;
    logic [IW-1:0]      recall_idx_q, recall_idx_d;
    logic               pause_q, pause_d;
    logic               counter_reset_q, counter_reset_d;
    logic               lap_view_q, lap_view_d;
    logic [C_BCD_W-1:0] display_q, display_d;

    logic               buf_wr, buf_clr;
    logic [C_BCD_W-1:0] buf_rd_data;
    logic [CW-1:0]      buf_count;

    // armed_q masks the first post-reset cycle so a button held through reset is not an edge.
    always_comb begin
        rise     = {btn_start_stop, btn_lap, btn_clear} & ~btn_prev_q & {3{armed_q}};
        ev_start = rise[2];
        ev_lap   = rise[1] & ~rise[2];
        ev_clear = rise[0] & ~rise[1] & ~rise[2];
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        split_d      = split_q;
        recall_idx_d = recall_idx_q;
        buf_wr       = 1'b0;
        buf_clr      = 1'b0;
        case (state_q)
            ST_CLEARED: if (ev_start) state_d = ST_RUNNING;
            ST_RUNNING, ST_SPLIT: begin
                if (ev_start) begin
                    state_d = ST_STOPPED;
                end else if (ev_lap) begin
                    state_d = ST_SPLIT;
                    buf_wr  = 1'b1;
                    split_d = time_bcd;
                    hold_d  = HOLD_CYCLES - 32'd1;
                end else if (state_q == ST_SPLIT) begin
                    if (hold_q == 32'd0) state_d = ST_RUNNING;
                    else                 hold_d  = hold_q - 32'd1;
                end
            end
            ST_STOPPED, ST_RECALL: begin
                if (ev_start) begin
                    state_d = ST_STOPPED;
                    if (state_q == ST_STOPPED) state_d = ST_RUNNING;
                end else if (ev_lap) begin
                    if (state_q == ST_RECALL) begin
                        if (CW'(recall_idx_q) + CW'(1) >= buf_count) recall_idx_d = '0;
                        else                                         recall_idx_d = recall_idx_q + IW'(1);
                    end else if (buf_count != '0) begin
                        state_d      = ST_RECALL;
                        recall_idx_d = '0;
                    end
                end else if (ev_clear) begin
                    state_d = ST_CLEARED;
                    buf_clr = 1'b1;
                end
            end
            default: state_d = ST_CLEARED;
        endcase
        if (state_d != ST_RECALL) recall_idx_d = '0;

        pause_d         = !(state_d == ST_RUNNING || state_d == ST_SPLIT);
        counter_reset_d = (state_d == ST_CLEARED) && (state_q != ST_CLEARED);
        lap_view_d      = (state_d == ST_SPLIT) || (state_d == ST_RECALL);
        display_d       = (state_d == ST_SPLIT) ? split_d : time_bcd;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            btn_prev_q      <= '0;
            armed_q         <= 1'b0;
            state_q         <= ST_CLEARED;
            hold_q          <= '0;
            split_q         <= '0;
            recall_idx_q    <= '0;
            pause_q         <= 1'b1;
            counter_reset_q <= 1'b1;
            lap_view_q      <= 1'b0;
            display_q       <= '0;
        end else begin
            btn_prev_q      <= {btn_start_stop, btn_lap, btn_clear};
            armed_q         <= 1'b1;
            state_q         <= state_d;
            hold_q          <= hold_d;
            split_q         <= split_d;
            recall_idx_q    <= recall_idx_d;
            pause_q         <= pause_d;
            counter_reset_q <= counter_reset_d;
            lap_view_q      <= lap_view_d;
            display_q       <= display_d;
        end
    end

    stopwatch_lap_buffer #(.DEPTH(DEPTH)) u_lap_buffer (
        .clk_in  (clk_in),
        .reset   (reset),
        .wr_en   (buf_wr),
        .wr_data (time_bcd),
        .clr     (buf_clr),
        .rd_age  (recall_idx_d),
        .rd_data (buf_rd_data),
        .count   (buf_count)
    );

    // In RECALL the buffer's registered read port drives the display directly (flop-to-pin mux).
    assign display_bcd   = (state_q == ST_RECALL) ? buf_rd_data : display_q;
    assign pause         = pause_q;
    assign counter_reset = counter_reset_q;
    assign lap_view      = lap_view_q;
    assign lap_count     = buf_count;
    assign recall_idx    = recall_idx_q;
    assign state         = state_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_lap_controller.sv
// ============================================================================
// Module      : tb_stopwatch_lap_controller
// Description : Directed self-checking bench for stopwatch_lap_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stopwatch_lap_controller;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        btn_start_stop, btn_lap, btn_clear;
    logic [15:0] time_bcd;
    logic        pause, counter_reset, lap_view;
    logic [15:0] display_bcd;
    logic [2:0]  lap_count;
    logic [1:0]  recall_idx;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_lap_controller #(.DEPTH(4), .HOLD_CYCLES(32'd8)) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .time_bcd       (time_bcd),
        .pause          (pause),
        .counter_reset  (counter_reset),
        .display_bcd    (display_bcd),
        .lap_view       (lap_view),
        .lap_count      (lap_count),
        .recall_idx     (recall_idx),
        .state          (state)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Button level high for one cycle; returns just after the edge that consumes the event.
    task automatic press_start();
        btn_start_stop = 1'b1; tick(); btn_start_stop = 1'b0;
    endtask

    task automatic press_lap();
        btn_lap = 1'b1; tick(); btn_lap = 1'b0;
    endtask

    task automatic press_clear();
        btn_clear = 1'b1; tick(); btn_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_start_stop = 1'b1; btn_lap = 1'b0; btn_clear = 1'b0; time_bcd = 16'h0000;
        repeat (3) tick();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", state); end
        n_checks++; if (pause !== 1'b1) begin n_fail++; $display("FAIL rst_pause got %b want 1", pause); end
        n_checks++; if (counter_reset !== 1'b1) begin n_fail++; $display("FAIL rst_creset got %b want 1", counter_reset); end
        n_checks++; if (display_bcd !== 16'h0000) begin n_fail++; $display("FAIL rst_display got %h want 0000", display_bcd); end
        n_checks++; if (lap_view !== 1'b0) begin n_fail++; $display("FAIL rst_lapview got %b want 0", lap_view); end
        n_checks++; if (lap_count !== 3'd0) begin n_fail++; $display("FAIL rst_lapcount got %0d want 0", lap_count); end
        n_checks++; if (recall_idx !== 2'd0) begin n_fail++; $display("FAIL rst_recallidx got %0d want 0", recall_idx); end
        reset = 1'b0;
        tick();
        n_checks++; if (counter_reset !== 1'b0) begin n_fail++; $display("FAIL post_rst_creset got %b want 0", counter_reset); end
        n_checks++; if (pause !== 1'b1) begin n_fail++; $display("FAIL post_rst_pause got %b want 1", pause); end
        n_checks++; if (display_bcd !== 16'h0000) begin n_fail++; $display("FAIL post_rst_display got %h want 0000", display_bcd); end
        tick();
        // start held through reset must not have started the watch
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL held_btn_state got %0d want 0", state); end
        btn_start_stop = 1'b0;
        tick(); tick();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL held_release_state got %0d want 0", state); end
    endtask

    task automatic test_start_stop();
        time_bcd = 16'h0042;
        press_start();
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL start_state got %0d want 1", state); end
        n_checks++; if (pause !== 1'b0) begin n_fail++; $display("FAIL start_pause got %b want 0", pause); end
        n_checks++; if (display_bcd !== 16'h0042) begin n_fail++; $display("FAIL start_display got %h want 0042", display_bcd); end
        for (int i = 0; i < 49; i++) begin
            time_bcd = 16'(i);
            tick();
            n_checks++; if (pause !== 1'b0 || display_bcd !== 16'(i)) begin
                n_fail++; $display("FAIL run_cycle%0d pause=%b display=%h want pause=0 display=%h", i, pause, display_bcd, 16'(i));
            end
        end
        press_start();
        n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL stop_state got %0d want 3", state); end
        n_checks++; if (pause !== 1'b1) begin n_fail++; $display("FAIL stop_pause got %b want 1", pause); end
        tick();
        press_lap();
        n_checks++; if (state !== 3'd3 || lap_view !== 1'b0) begin
            n_fail++; $display("FAIL lap_no_laps state=%0d lap_view=%b want 3/0", state, lap_view);
        end
        tick();
    endtask

    task automatic test_split();
        press_start(); tick();
        time_bcd = 16'h1234;
        press_lap();
        n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL split_state got %0d want 2", state); end
        n_checks++; if (display_bcd !== 16'h1234 || lap_view !== 1'b1) begin
            n_fail++; $display("FAIL split_entry display=%h lap_view=%b want 1234/1", display_bcd, lap_view);
        end
        n_checks++; if (lap_count !== 3'd1) begin n_fail++; $display("FAIL split_count got %0d want 1", lap_count); end
        for (int i = 1; i < 8; i++) begin
            time_bcd = 16'h5000 + 16'(i);
            tick();
            n_checks++; if (state !== 3'd2 || display_bcd !== 16'h1234 || lap_view !== 1'b1 || pause !== 1'b0) begin
                n_fail++; $display("FAIL split_hold%0d state=%0d display=%h lap_view=%b pause=%b want 2/1234/1/0", i, state, display_bcd, lap_view, pause);
            end
        end
        time_bcd = 16'h0777;
        tick();
        n_checks++; if (state !== 3'd1 || lap_view !== 1'b0 || display_bcd !== 16'h0777 || pause !== 1'b0) begin
            n_fail++; $display("FAIL split_expire state=%0d lap_view=%b display=%h pause=%b want 1/0/0777/0", state, lap_view, display_bcd, pause);
        end
    endtask

    task automatic test_lap_ring();
        logic [15:0] exp_val [5] = '{16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0005};
        logic [1:0]  exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 1; k <= 5; k++) begin
            time_bcd = 16'(k);
            press_lap(); tick();
        end
        n_checks++; if (lap_count !== 3'd4) begin n_fail++; $display("FAIL ring_count got %0d want 4", lap_count); end
        press_start();
        n_checks++; if (state !== 3'd3 || pause !== 1'b1) begin
            n_fail++; $display("FAIL ring_stop state=%0d pause=%b want 3/1", state, pause);
        end
        tick();
        for (int j = 0; j < 5; j++) begin
            time_bcd = 16'hAAA0 + 16'(j);
            press_lap();
            n_checks++; if (state !== 3'd4 || recall_idx !== exp_idx[j] || display_bcd !== exp_val[j] || lap_view !== 1'b1 || pause !== 1'b1) begin
                n_fail++; $display("FAIL recall%0d state=%0d idx=%0d display=%h lap_view=%b pause=%b want 4/%0d/%h/1/1",
                                   j, state, recall_idx, display_bcd, lap_view, pause, exp_idx[j], exp_val[j]);
            end
            tick();
        end
        time_bcd = 16'h0321;
        press_start();
        n_checks++; if (state !== 3'd3 || lap_view !== 1'b0 || display_bcd !== 16'h0321 || pause !== 1'b1) begin
            n_fail++; $display("FAIL recall_exit state=%0d lap_view=%b display=%h pause=%b want 3/0/0321/1", state, lap_view, display_bcd, pause);
        end
        tick();
        press_clear();
        n_checks++; if (state !== 3'd0 || lap_count !== 3'd0 || counter_reset !== 1'b1) begin
            n_fail++; $display("FAIL clear4 state=%0d count=%0d creset=%b want 0/0/1", state, lap_count, counter_reset);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        press_lap(); tick();
        press_clear();
        n_checks++; if (state !== 3'd0 || counter_reset !== 1'b0) begin
            n_fail++; $display("FAIL cleared_ignore state=%0d creset=%b want 0/0", state, counter_reset);
        end
        tick();
        press_start(); tick();
        press_clear();
        n_checks++; if (state !== 3'd1 || counter_reset !== 1'b0 || pause !== 1'b0) begin
            n_fail++; $display("FAIL run_clear state=%0d creset=%b pause=%b want 1/0/0", state, counter_reset, pause);
        end
        tick();
        time_bcd = 16'h0909;
        btn_start_stop = 1'b1; btn_lap = 1'b1;
        tick();
        btn_start_stop = 1'b0; btn_lap = 1'b0;
        n_checks++; if (state !== 3'd3 || lap_count !== 3'd0 || lap_view !== 1'b0) begin
            n_fail++; $display("FAIL start_lap_same state=%0d count=%0d lap_view=%b want 3/0/0", state, lap_count, lap_view);
        end
        tick();
    endtask

    task automatic test_clear_two_laps();
        press_start(); tick();
        time_bcd = 16'h0011; press_lap(); tick();
        time_bcd = 16'h0022; press_lap(); tick();
        n_checks++; if (lap_count !== 3'd2) begin n_fail++; $display("FAIL two_count got %0d want 2", lap_count); end
        press_start(); tick();
        press_clear();
        n_checks++; if (state !== 3'd0 || counter_reset !== 1'b1 || lap_count !== 3'd0 || pause !== 1'b1) begin
            n_fail++; $display("FAIL clear2 state=%0d creset=%b count=%0d pause=%b want 0/1/0/1", state, counter_reset, lap_count, pause);
        end
        tick();
        n_checks++; if (counter_reset !== 1'b0 || state !== 3'd0) begin
            n_fail++; $display("FAIL clear2_pulse creset=%b state=%0d want 0/0", counter_reset, state);
        end
        tick();
        press_start(); tick();
        press_start(); tick();
        press_lap();
        n_checks++; if (state !== 3'd3 || lap_view !== 1'b0) begin
            n_fail++; $display("FAIL empty_recall state=%0d lap_view=%b want 3/0", state, lap_view);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_split();
        test_lap_ring();
        test_back_to_back();
        test_clear_two_laps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
